// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a start bit, shifts out
// 8 data bits LSB first + odd parity + stop on device falling edges, then checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       ack_error,
  output logic       timeout_error
);

  localparam int CW = 19;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic          done_q, done_d;
  logic          ackerr_q, ackerr_d;
  logic          tout_q, tout_d;
  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic          fall;
  logic          active;

  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_prev_q <= 1'b0;
      dat_s1_q   <= 1'b0;
      dat_s2_q   <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall   = clk_prev_q & ~clk_s2_q;
  assign active = (state_q == S_START) || (state_q == S_SEND) ||
                  (state_q == S_ACK)   || (state_q == S_WAIT_IDLE);

  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      done_q    <= 1'b0;
      ackerr_q  <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      done_q    <= done_d;
      ackerr_q  <= ackerr_d;
      tout_q    <= tout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    ackerr_d  = 1'b0;
    tout_d    = 1'b0;

    // Any device edge restarts the watchdog; otherwise it counts up to the limit.
    if (active) begin
      if (fall) begin
        cnt_d = '0;
      end else if (cnt_q >= TO_LAST) begin
        tout_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shreg_d   = {1'b1, ~^tx_byte, tx_byte};
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q >= INH_LAST) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        if (fall) begin
          bit_cnt_d = 4'd1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        // Edge 10 shifts in the stop bit; ACK keeps the line released.
        if (fall) begin
          shreg_d   = {1'b1, shreg_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          if (dat_s2_q) begin
            ackerr_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2_q && dat_s2_q) begin
          done_d  = 1'b1;
          tout_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line drives decode straight from state so reset releases them without a clock.
  assign ps2_clk_oe    = (state_q == S_INHIBIT);
  assign ps2_data_oe   = ((state_q == S_INHIBIT) && (cnt_q == INH_LAST)) ||
                         (state_q == S_START) ||
                         ((state_q == S_SEND) && !shreg_q[0]);
  assign busy          = (state_q != S_IDLE);
  assign tx_done       = done_q;
  assign ack_error     = ackerr_q;
  assign timeout_error = tout_q;

endmodule
